// File: rtl/brush_stamper.sv
// brush_stamper: expands one paint command into a row-major scan of pixel-store writes.
// Optional full-frame clear is built only when CLEAR_CMD_EN is defined.
module brush_stamper #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 8,
  parameter int COLOR_W  = 3,
  parameter int SIZE_W   = 3,
  parameter int BG_COLOR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [X_W-1:0]     cmd_x,
  input  logic [Y_W-1:0]     cmd_y,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic [SIZE_W-1:0]  cmd_size,
  input  logic               cmd_erase,
  input  logic               cmd_clear,
  output logic               wr_en,
  output logic [X_W-1:0]     wr_x,
  output logic [Y_W-1:0]     wr_y,
  output logic [COLOR_W-1:0] wr_color,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STAMP = 2'd1;
`ifdef CLEAR_CMD_EN
  localparam logic [1:0] CLEAR = 2'd2;
  localparam logic [X_W-1:0] X_MAX = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(HEIGHT - 1);
  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);
`endif
  localparam logic [X_W+1:0]     X_LIM = (X_W+2)'(WIDTH);
  localparam logic [Y_W+1:0]     Y_LIM = (Y_W+2)'(HEIGHT);
  localparam logic [COLOR_W-1:0] BG    = COLOR_W'(BG_COLOR);
  localparam logic [SIZE_W:0]    D_ONE = (SIZE_W+1)'(1);

  logic [1:0]        state;
  logic [X_W-1:0]    lat_x;
  logic [Y_W-1:0]    lat_y;
  logic [SIZE_W-1:0] lat_size;
  logic [SIZE_W:0]   dx, dy;

  logic [X_W-1:0]    base_x;
  logic [Y_W-1:0]    base_y;
  logic [SIZE_W:0]   rad, n_dx, n_dy;
  logic [X_W+1:0]    px;
  logic [Y_W+1:0]    py;
  logic              n_in, n_last;

  assign cmd_ready = (state == IDLE);
  assign busy      = !cmd_ready;

  // Next stamp point: the first offset (-r,-r) when idle, otherwise the successor of (dx,dy).
  always_comb begin
    base_x = lat_x;
    base_y = lat_y;
    rad    = {1'b0, lat_size};
    n_dx   = dx;
    n_dy   = dy;
    if (state == IDLE) begin
      base_x = cmd_x;
      base_y = cmd_y;
      rad    = {1'b0, cmd_size};
      n_dx   = -rad;
      n_dy   = -rad;
    end else if (dx == rad) begin
      n_dx = -rad;
      n_dy = dy + D_ONE;
    end else begin
      n_dx = dx + D_ONE;
    end
    px     = {2'b00, base_x} + {{(X_W+1-SIZE_W){n_dx[SIZE_W]}}, n_dx};
    py     = {2'b00, base_y} + {{(Y_W+1-SIZE_W){n_dy[SIZE_W]}}, n_dy};
    n_in   = !px[X_W+1] && (px < X_LIM) && !py[Y_W+1] && (py < Y_LIM);
    n_last = (n_dx == rad) && (n_dy == rad);
  end

`ifdef CLEAR_CMD_EN
  logic [X_W-1:0] clr_nx;
  logic [Y_W-1:0] clr_ny;

  // The clear scan uses the write address itself as its raster counter.
  always_comb begin
    clr_nx = wr_x + X_ONE;
    clr_ny = wr_y;
    if (wr_x == X_MAX) begin
      clr_nx = '0;
      clr_ny = wr_y + Y_ONE;
    end
  end
`else
  logic unused_clear;
  assign unused_clear = cmd_clear;
`endif

  // done marks the point currently on the outputs as the last one, so it also ends the scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lat_x    <= '0;
      lat_y    <= '0;
      lat_size <= '0;
      dx       <= '0;
      dy       <= '0;
      wr_en    <= 1'b0;
      wr_x     <= '0;
      wr_y     <= '0;
      wr_color <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            lat_x    <= cmd_x;
            lat_y    <= cmd_y;
            lat_size <= cmd_size;
`ifdef CLEAR_CMD_EN
            if (cmd_clear) begin
              state    <= CLEAR;
              wr_en    <= 1'b1;
              wr_x     <= '0;
              wr_y     <= '0;
              wr_color <= BG;
              done     <= (WIDTH * HEIGHT == 1);
            end else
`endif
            begin
              state    <= STAMP;
              dx       <= n_dx;
              dy       <= n_dy;
              wr_en    <= n_in;
              wr_x     <= px[X_W-1:0];
              wr_y     <= py[Y_W-1:0];
              wr_color <= cmd_erase ? BG : cmd_color;
              done     <= n_last;
            end
          end
        end
        STAMP: begin
          if (done) begin
            state <= IDLE;
            wr_en <= 1'b0;
            done  <= 1'b0;
          end else begin
            dx    <= n_dx;
            dy    <= n_dy;
            wr_en <= n_in;
            wr_x  <= px[X_W-1:0];
            wr_y  <= py[Y_W-1:0];
            done  <= n_last;
          end
        end
`ifdef CLEAR_CMD_EN
        CLEAR: begin
          if (done) begin
            state <= IDLE;
            wr_en <= 1'b0;
            done  <= 1'b0;
          end else begin
            wr_x <= clr_nx;
            wr_y <= clr_ny;
            done <= (clr_nx == X_MAX) && (clr_ny == Y_MAX);
          end
        end
`endif
        default: begin
          state <= IDLE;
          wr_en <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
